// File: rtl/ram_pkg.sv
// Shared definitions for the data RAM controller: default geometry,
// controller state encoding and the fill value used by the clear sequence.
package ram_pkg;

    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DATA_W = 16;
    localparam int RAM_DEPTH  = 2 ** RAM_ADDR_W;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam logic [RAM_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/data_ram_ctrl_if.sv
// CPU-side request/status bundle of the data RAM. The bidirectional data bus
// is kept outside the interface as a plain inout on the controller.
interface data_ram_ctrl_if
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W
) ();

    logic [ADDR_W-1:0] address_to_ram;
    logic              write_enable_to_ram;
    logic              read_enable_to_ram;
    logic              enable_ram_read;
    logic              ram_ready;
    logic              read_valid;
    logic              bus_conflict;

    // CPU side: issues requests, observes status
    modport master (
        output address_to_ram,
        output write_enable_to_ram,
        output read_enable_to_ram,
        output enable_ram_read,
        input  ram_ready,
        input  read_valid,
        input  bus_conflict
    );

    // Memory side: consumes requests, reports status
    modport slave (
        input  address_to_ram,
        input  write_enable_to_ram,
        input  read_enable_to_ram,
        input  enable_ram_read,
        output ram_ready,
        output read_valid,
        output bus_conflict
    );

endinterface

// File: rtl/ram_core.sv
// DEPTH x DATA_W storage array with one synchronous write port and one
// registered read port. A same-edge write to the read address is forwarded
// so the read port returns the new word (write-first).
module ram_core
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store the word at the rising edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: register the addressed word, forwarding a colliding write
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM controller: zero-fills the array after reset, then serves CPU
// writes (data taken from data_ram) and one-cycle-latency reads returned by
// tri-state driving of data_ram. Simultaneous write+read is flagged as a
// sticky bus conflict.
module data_ram_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W         = RAM_ADDR_W,
    parameter int DATA_W         = RAM_DATA_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    data_ram_ctrl_if.slave    bus,
    inout  wire  [DATA_W-1:0] data_ram
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_cnt;

    logic              ready;
    logic              clr_we;
    logic              wr_req;
    logic              rd_req;
    logic              conflict_req;

    logic              core_we;
    logic [ADDR_W-1:0] core_waddr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;
    logic              conflict_q;
    logic              drive;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave the fill after the last word is written, or at once when fill is disabled
    always_comb begin
        state_next = state;
        case (state)
            S_CLEAR: begin
                if (!CLEAR_ON_RESET || (clr_cnt == LAST_ADDR)) begin
                    state_next = S_READY;
                end
            end
            S_READY: state_next = S_READY;
            default: state_next = S_CLEAR;
        endcase
    end

    // Outputs per state: fill write during clear, request decode once ready
    always_comb begin
        ready        = 1'b0;
        clr_we       = 1'b0;
        wr_req       = 1'b0;
        rd_req       = 1'b0;
        conflict_req = 1'b0;
        case (state)
            S_CLEAR: begin
                clr_we = CLEAR_ON_RESET;
            end
            S_READY: begin
                ready        = 1'b1;
                conflict_req = bus.write_enable_to_ram && bus.read_enable_to_ram
                               && bus.enable_ram_read;
                wr_req       = bus.write_enable_to_ram && !conflict_req;
                rd_req       = bus.read_enable_to_ram && bus.enable_ram_read
                               && !bus.write_enable_to_ram;
            end
            default: ;
        endcase
    end

    // Clear counter: walks every address once while filling
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt <= '0;
        end else if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Write port mux: fill sequence owns the port during clear
    assign core_we    = clr_we || wr_req;
    assign core_waddr = clr_we ? clr_cnt : bus.address_to_ram;
    assign core_wdata = clr_we ? DATA_W'(ZERO_WORD) : data_ram;

    ram_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .re    (rd_req),
        .raddr (bus.address_to_ram),
        .rdata (rdata_p1)
    );

    // ---- stage p0 -> p1: read accepted, word registered in the core ----
    // Read-valid pipeline: one drive cycle per accepted read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_req;
        end
    end

    // Sticky conflict flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_q <= 1'b0;
        end else if (conflict_req) begin
            conflict_q <= 1'b1;
        end
    end

    // A write request releases the bus combinationally so the CPU never fights the return data
    assign drive    = vld_p1 && !bus.write_enable_to_ram;
    assign data_ram = drive ? rdata_p1 : {DATA_W{1'bz}};

    assign bus.ram_ready    = ready;
    assign bus.read_valid   = drive;
    assign bus.bus_conflict = conflict_q;

endmodule

// File: doc/data_ram_ctrl.md
Name: data_ram_ctrl

Overview:
- Single-port 64x16 data memory that sits directly downstream of the CPU's RAM interface.
- Consumes address_to_ram, write_enable_to_ram, read_enable_to_ram and enable_ram_read, and owns the far side of the bidirectional data_ram bus.
- After reset it zero-fills the array, then serves synchronous writes and one-cycle-latency reads.
- Reads are returned by tri-state driving of data_ram, and the block flags illegal bus requests.

Parameters:
- ADDR_W, 6, address width; sets DEPTH = 2**ADDR_W = 64 words.
- DATA_W, 16, word width and data_ram bus width.
- CLEAR_ON_RESET, 1:
  - 1 = zero-fill every word after reset.
  - 0 = skip the fill; ready one cycle after reset release.

Ports:
- clk  input  1  system clock; rising-edge.
- reset  input  1  asynchronous, active-low reset.
- address_to_ram  input  ADDR_W  word address from CPU.
- write_enable_to_ram  input  1  write request; data sampled from data_ram.
- read_enable_to_ram  input  1  read request.
- enable_ram_read  input  1  read-path enable; a read happens only when this and read_enable_to_ram are both high.
- data_ram  inout  DATA_W  shared bus; this block drives it only while returning read data, otherwise Z.
- ram_ready  output  1  high once the clear sequence is complete; requests are accepted only when high.
- read_valid  output  1  high in the cycle this block drives data_ram.
- bus_conflict  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=S_CLEAR (or S_READY-pending if CLEAR_ON_RESET=0); clear counter=0.
  - ram_ready=0, read_valid=0, bus_conflict=0, data_ram=Z.
  - Array contents are not reset asynchronously.
- FSM states S_CLEAR and S_READY:
  - S_CLEAR: each clock writes 0 to mem[cnt] and increments cnt. When cnt=DEPTH-1 is written, go to S_READY at that edge; ram_ready rises in the following cycle.
  - The fill takes exactly DEPTH=64 cycles after reset release.
  - CLEAR_ON_RESET=0: S_READY is entered at the first edge after reset release.
  - All CPU requests in S_CLEAR are ignored: no write, no read, no conflict flag.
- Reset asserted mid-clear: the sequence aborts immediately and restarts from address 0 after release.
- Write (S_READY, write_enable_to_ram=1, read request absent):
  - mem[address_to_ram] <= data_ram at the rising edge.
  - The block never drives data_ram while write_enable_to_ram=1.
- Read (S_READY, read_enable_to_ram=1, enable_ram_read=1, write_enable_to_ram=0):
  - mem[address_to_ram] is registered at edge k.
  - data_ram is driven with that word and read_valid=1 from edge k until edge k+1.
  - Latency is 1 cycle; throughput is 1 read per cycle with back-to-back reads pipelined.
  - read_enable_to_ram without enable_ram_read is a no-op.
- Write then read of the same address on consecutive cycles: the read returns the newly written data.
- Write asserted during a drive cycle: output drivers release combinationally as soon as write_enable_to_ram=1, which prevents contention. The write proceeds normally and read_valid is forced to 0 that cycle.
- Write and read asserted together in S_READY:
  - Illegal; no write and no read occur.
  - bus_conflict sets at that edge and stays high until reset.
  - Any drive in progress releases as for a write.
- Addresses are always in range (6 bits covers 64 words); there is no wrap logic beyond the natural width.
- The clear counter is ADDR_W bits wide. Termination is detected on cnt==DEPTH-1, not on overflow.

Decomposition:
- Package ram_pkg holds:
  - ADDR_W and DATA_W defaults and DEPTH.
  - The state enum {S_CLEAR, S_READY}.
  - A ZERO_WORD constant.
- One sub-module, ram_core:
  - DEPTH x DATA_W array, one synchronous write port and one registered synchronous read port, with write-first semantics.
  - data_ram_ctrl holds the FSM, clear counter, request decode, tri-state driver and conflict flag.

Test Plan:
- Release reset, hold all requests low for 70 cycles:
  - ram_ready=0 for cycles 1-64 and rises at cycle 65.
  - Reads then return 16'h0000 at addresses 0, 31 and 63.
- In S_READY, write 16'hA5C3 to addr 6'h2A, then read addr 6'h2A next cycle:
  - data_ram=16'hA5C3 with read_valid=1 exactly one cycle after the read request.
  - data_ram=Z otherwise.
- Back-to-back reads of addr 1, 2, 3 after writes of 16'h0011, 16'h0022, 16'h0033:
  - Three consecutive drive cycles with those values, no bubbles.
- Assert write_enable_to_ram and read_enable_to_ram together (addr 5, bus=16'hFFFF):
  - bus_conflict=1 thereafter and mem[5] unchanged (reads 16'h0000).
  - Pulse reset: bus_conflict returns to 0.
- Pulse reset low at clear cycle 30:
  - Outputs reset immediately.
  - After release, ram_ready rises 64 cycles later, not 34.
- Issue a read with enable_ram_read=0, and a write during S_CLEAR:
  - No drive and read_valid=0.
  - The target word is still 0 after the clear completes.
